// File: rtl/mvm_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mvm_sequencer_if
//  Description : Handshake bundle between the host-side MVM sequencer and the
//                sparse MVM accelerator.
//                  master : sequencer side (drives strobes, row/col/value)
//                  slave  : accelerator side (drives ready, result, toggle)
//  Signals     : mvm_start, mvm_row_val[1:0], mvm_column_val[1:0],
//                mvm_value[7:0], mvm_sending_cpu, mvm_done_list,
//                mvm_fetch_ready, mvm_output_val[7:0], mvm_sending_out
//  Revision    : 1.0  initial release
// ============================================================================
interface mvm_sequencer_if;
  logic       mvm_start;
  logic [1:0] mvm_row_val;
  logic [1:0] mvm_column_val;
  logic [7:0] mvm_value;
  logic       mvm_sending_cpu;
  logic       mvm_done_list;
  logic       mvm_fetch_ready;
  logic [7:0] mvm_output_val;
  logic       mvm_sending_out;

  modport master (
    output mvm_start,
    output mvm_row_val,
    output mvm_column_val,
    output mvm_value,
    output mvm_sending_cpu,
    output mvm_done_list,
    input  mvm_fetch_ready,
    input  mvm_output_val,
    input  mvm_sending_out
  );

  modport slave (
    input  mvm_start,
    input  mvm_row_val,
    input  mvm_column_val,
    input  mvm_value,
    input  mvm_sending_cpu,
    input  mvm_done_list,
    output mvm_fetch_ready,
    output mvm_output_val,
    output mvm_sending_out
  );
endinterface
`default_nettype wire

// File: rtl/mvm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mvm_sequencer
//  Description : Host-side controller for the sparse MVM accelerator. Holds
//                one CSR-encoded 3x3 matrix (up to MAX_NNZ entries) and a
//                3-bit spike train; on go it streams the entries, the
//                end-of-list strobe and the spike byte to the accelerator,
//                then captures the three result bytes from the accelerator's
//                toggle-signalled output stream. The matrix is retained
//                across runs.
//  Parameters  : MAX_NNZ  entry buffer depth
//                TIMEOUT  watchdog limit in cycles (watchdog builds only)
//  Build macro : MVM_SEQ_WATCHDOG_EN - enables the wait-state watchdog; when
//                undefined the waits are unbounded and error stays 0.
//  Ports       : clk, rst_n (async, active low)
//                cfg_wr/cfg_row/cfg_col/cfg_val/cfg_clr/cfg_full : buffer
//                spike_wr/spike_in                               : spike reg
//                go/busy/done/error                              : run ctrl
//                res0/res1/res2                                  : results
//                acc (mvm_sequencer_if.master)                   : accel bus
//  Revision    : 1.0  initial release
// ============================================================================
module mvm_sequencer #(
  parameter int MAX_NNZ = 9,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_wr,
  input  logic [1:0] cfg_row,
  input  logic [1:0] cfg_col,
  input  logic [7:0] cfg_val,
  input  logic       cfg_clr,
  output logic       cfg_full,
  input  logic       spike_wr,
  input  logic [2:0] spike_in,
  input  logic       go,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] res0,
  output logic [7:0] res1,
  output logic [7:0] res2,
  mvm_sequencer_if.master acc
);

  localparam int                 c_idx_w   = $clog2(MAX_NNZ + 1);
  localparam logic [c_idx_w-1:0] c_max_nnz = c_idx_w'(MAX_NNZ);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    START      = 4'd1,
    SETTLE     = 4'd2,
    SEND       = 4'd3,
    GAP        = 4'd4,
    LIST_DONE  = 4'd5,
    TRAIN_WAIT = 4'd6,
    TRAIN      = 4'd7,
    COLLECT    = 4'd8
  } state_t;

  // CSR entry storage (no reset needed: only entries below r_nnz are read)
  logic [1:0] r_ent_row [MAX_NNZ];
  logic [1:0] r_ent_col [MAX_NNZ];
  logic [7:0] r_ent_val [MAX_NNZ];

  state_t             r_state;
  logic [c_idx_w-1:0] r_nnz;
  logic [c_idx_w-1:0] r_idx;
  logic [2:0]         r_spike;
  logic               r_skip;     // TRAIN_WAIT has spent its mandatory idle cycle
  logic               r_sout_q;   // last seen level of mvm_sending_out
  logic [1:0]         r_tog;      // index of the next toggle in COLLECT
  logic               r_busy;
  logic               r_done;
  logic               r_error;
  logic [7:0]         r_res0;
  logic [7:0]         r_res1;
  logic [7:0]         r_res2;
  logic               r_start;
  logic               r_cpu;
  logic               r_list;
  logic [1:0]         r_row;
  logic [1:0]         r_col;
  logic [7:0]         r_val;

  logic w_idle;
  logic w_wr_ok;
  logic w_toggle;
  logic w_wd_expire;

  assign w_idle   = (r_state == IDLE);
  // Clear beats a simultaneous write; writes into a full buffer are dropped.
  assign w_wr_ok  = w_idle && cfg_wr && !cfg_clr && (r_nnz != c_max_nnz);
  assign w_toggle = acc.mvm_sending_out ^ r_sout_q;

`ifdef MVM_SEQ_WATCHDOG_EN
  localparam int                c_wd_w     = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [c_wd_w-1:0] c_wd_limit = c_wd_w'(TIMEOUT - 1);

  logic [c_wd_w-1:0] r_wd_cnt;
  logic              w_wd_wait;

  // Every wait state is entered from a non-wait state, so holding the count
  // at zero outside the wait states restarts it on each state change.
  assign w_wd_wait = (r_state == GAP) || (r_state == TRAIN_WAIT) || (r_state == COLLECT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (!w_wd_wait || ((r_state == COLLECT) && w_toggle)) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign w_wd_expire = w_wd_wait && (r_wd_cnt == c_wd_limit);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_wd_expire      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_ent_row[r_nnz] <= cfg_row;
      r_ent_col[r_nnz] <= cfg_col;
      r_ent_val[r_nnz] <= cfg_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_nnz    <= '0;
      r_idx    <= '0;
      r_spike  <= '0;
      r_skip   <= 1'b0;
      r_sout_q <= 1'b0;
      r_tog    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_res0   <= '0;
      r_res1   <= '0;
      r_res2   <= '0;
      r_start  <= 1'b0;
      r_cpu    <= 1'b0;
      r_list   <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_val    <= '0;
    end else begin
      // Strobes are single-cycle: default low, raised only by their state.
      r_start <= 1'b0;
      r_cpu   <= 1'b0;
      r_list  <= 1'b0;

      case (r_state)
        IDLE: begin
          if (cfg_clr) begin
            r_nnz   <= '0;
            r_error <= 1'b0;
          end else if (w_wr_ok) begin
            r_nnz <= r_nnz + 1'b1;
          end
          if (spike_wr) begin
            r_spike <= spike_in;
          end
          if (go) begin
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_idx   <= '0;
            r_state <= START;
          end
        end

        START: begin
          r_start <= 1'b1;
          r_state <= SETTLE;
        end

        SETTLE: begin
          r_state <= (r_idx < r_nnz) ? SEND : LIST_DONE;
        end

        SEND: begin
          r_cpu   <= 1'b1;
          r_row   <= r_ent_row[r_idx];
          r_col   <= r_ent_col[r_idx];
          r_val   <= r_ent_val[r_idx];
          r_idx   <= r_idx + 1'b1;
          r_state <= GAP;
        end

        GAP: begin
          if (acc.mvm_fetch_ready) begin
            r_state <= (r_idx < r_nnz) ? SEND : LIST_DONE;
          end
        end

        LIST_DONE: begin
          r_list  <= 1'b1;
          r_skip  <= 1'b0;
          r_state <= TRAIN_WAIT;
        end

        TRAIN_WAIT: begin
          // First cycle is skipped so the accelerator's ready flag reflects
          // the end-of-list strobe rather than the last entry.
          if (!r_skip) begin
            r_skip <= 1'b1;
          end else if (acc.mvm_fetch_ready) begin
            r_state <= TRAIN;
          end
        end

        TRAIN: begin
          r_cpu    <= 1'b1;
          r_val    <= {5'b0, r_spike};
          r_sout_q <= acc.mvm_sending_out;
          r_tog    <= '0;
          r_state  <= COLLECT;
        end

        COLLECT: begin
          if (w_toggle) begin
            r_sout_q <= acc.mvm_sending_out;
            r_tog    <= r_tog + 1'b1;
            // Toggle 0 marks entry into transmit with stale data: dropped.
            case (r_tog)
              2'd1: r_res0 <= acc.mvm_output_val;
              2'd2: r_res1 <= acc.mvm_output_val;
              2'd3: begin
                r_res2  <= acc.mvm_output_val;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
              default: ;
            endcase
          end
        end

        default: r_state <= IDLE;
      endcase

      // Watchdog abort overrides whatever the wait state decided.
      if (w_wd_expire) begin
        r_start <= 1'b0;
        r_cpu   <= 1'b0;
        r_list  <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
        r_error <= 1'b1;
        r_state <= IDLE;
      end
    end
  end

  assign cfg_full           = (r_nnz == c_max_nnz);
  assign busy               = r_busy;
  assign done               = r_done;
  assign error              = r_error;
  assign res0               = r_res0;
  assign res1               = r_res1;
  assign res2               = r_res2;
  assign acc.mvm_start       = r_start;
  assign acc.mvm_sending_cpu = r_cpu;
  assign acc.mvm_done_list   = r_list;
  assign acc.mvm_row_val     = r_row;
  assign acc.mvm_column_val  = r_col;
  assign acc.mvm_value       = r_val;

endmodule
`default_nettype wire

// File: tb/tb_mvm_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mvm_sequencer
//  Description : Directed self-checking bench for mvm_sequencer with a small
//                behavioural accelerator that records the streamed entries,
//                computes the row sums and returns them on a toggle stream.
//                The watchdog scenario is built only with MVM_SEQ_WATCHDOG_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mvm_sequencer;

`ifdef MVM_SEQ_WATCHDOG_EN
  localparam int TB_TIMEOUT = 20;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_wr = 1'b0;
  logic [1:0] cfg_row = '0;
  logic [1:0] cfg_col = '0;
  logic [7:0] cfg_val = '0;
  logic       cfg_clr = 1'b0;
  logic       cfg_full;
  logic       spike_wr = 1'b0;
  logic [2:0] spike_in = '0;
  logic       go = 1'b0;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] res0;
  logic [7:0] res1;
  logic [7:0] res2;

  mvm_sequencer_if acc ();

  mvm_sequencer #(
    .MAX_NNZ (9),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_wr   (cfg_wr),
    .cfg_row  (cfg_row),
    .cfg_col  (cfg_col),
    .cfg_val  (cfg_val),
    .cfg_clr  (cfg_clr),
    .cfg_full (cfg_full),
    .spike_wr (spike_wr),
    .spike_in (spike_in),
    .go       (go),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .res0     (res0),
    .res1     (res1),
    .res2     (res2),
    .acc      (acc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- behavioural accelerator ----------------
  int         m_phase = 0;
  int         m_n = 0;
  int         m_cnt = 0;
  int         m_k = 0;
  int         m_list_n = -1;
  int         m_start_cnt = 0;
  int         m_viol = 0;
  int         m_strobe_cnt = 0;
  logic       m_stall = 1'b0;
  logic [1:0] m_row [16];
  logic [1:0] m_col [16];
  logic [7:0] m_val [16];
  logic [7:0] m_sum [3];
  logic [2:0] m_spike;
  logic       p_start = 1'b0;
  logic       p_cpu = 1'b0;
  logic       p_list = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = 0;
      m_n = 0;
      m_cnt = 0;
      m_k = 0;
      p_start = 1'b0;
      p_cpu = 1'b0;
      p_list = 1'b0;
      acc.mvm_fetch_ready = 1'b1;
      acc.mvm_sending_out = 1'b1;
      acc.mvm_output_val = 8'h00;
    end else begin
      if ((p_start && acc.mvm_start) || (p_cpu && acc.mvm_sending_cpu) ||
          (p_list && acc.mvm_done_list)) m_viol++;
      p_start = acc.mvm_start;
      p_cpu   = acc.mvm_sending_cpu;
      p_list  = acc.mvm_done_list;
      if (acc.mvm_start || acc.mvm_sending_cpu || acc.mvm_done_list) m_strobe_cnt++;
      acc.mvm_fetch_ready = !(m_stall && (m_n > 0));
      if (acc.mvm_start) begin
        m_start_cnt++;
        m_phase = 0;
        m_n = 0;
      end
      case (m_phase)
        0: begin
          if (acc.mvm_sending_cpu) begin
            if (m_n < 16) begin
              m_row[m_n] = acc.mvm_row_val;
              m_col[m_n] = acc.mvm_column_val;
              m_val[m_n] = acc.mvm_value;
            end
            m_n++;
            acc.mvm_fetch_ready = 1'b0;
          end
          if (acc.mvm_done_list) begin
            m_list_n = m_n;
            m_phase = 1;
          end
        end
        1: begin
          if (acc.mvm_sending_cpu) begin
            m_spike = acc.mvm_value[2:0];
            for (int r = 0; r < 3; r++) m_sum[r] = 8'h00;
            for (int i = 0; i < m_n && i < 16; i++)
              if (m_spike[m_col[i]] === 1'b1) m_sum[m_row[i]] = m_sum[m_row[i]] + m_val[i];
            m_phase = 2;
            m_cnt = 0;
            m_k = 0;
            acc.mvm_fetch_ready = 1'b0;
          end
        end
        2: begin
          m_cnt++;
          if (m_cnt == 2) begin
            m_cnt = 0;
            if (m_k == 0) acc.mvm_output_val = 8'hEE;
            else if (m_k <= 3) acc.mvm_output_val = m_sum[m_k-1];
            if (m_k <= 4) begin
              acc.mvm_sending_out = ~acc.mvm_sending_out;
            end else begin
              acc.mvm_sending_out = 1'b1;
              m_phase = 3;
            end
            m_k++;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- host helpers (called at a negedge) ----------------
  task automatic wr_entry(input logic [1:0] r, input logic [1:0] c, input logic [7:0] v);
    cfg_row = r; cfg_col = c; cfg_val = v; cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  task automatic load_spike(input logic [2:0] s);
    spike_in = s; spike_wr = 1'b1;
    @(negedge clk);
    spike_wr = 1'b0;
  endtask

  task automatic clear_buf();
    cfg_clr = 1'b1;
    @(negedge clk);
    cfg_clr = 1'b0;
  endtask

  task automatic load_matrix_a();
    wr_entry(2'd0, 2'd0, 8'd3);
    wr_entry(2'd0, 2'd2, 8'd5);
    wr_entry(2'd1, 2'd1, 8'd7);
    wr_entry(2'd2, 2'd0, 8'd2);
    wr_entry(2'd2, 2'd2, 8'd4);
  endtask

  task automatic wait_done(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input int en);
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".res0"}, res0, e0);
    chk({tag, ".res1"}, res1, e1);
    chk({tag, ".res2"}, res2, e2);
    chk({tag, ".entries"}, m_list_n, en);
  endtask

  task automatic run_go(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input int en);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_done(tag, e0, e1, e2, en);
  endtask

  function automatic logic [63:0] all_outs();
    return {21'd0, busy, done, error, cfg_full, res0, res1, res2,
            acc.mvm_start, acc.mvm_sending_cpu, acc.mvm_done_list,
            acc.mvm_row_val, acc.mvm_column_val, acc.mvm_value};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int starts0;
    int strobes0;

    repeat (3) @(negedge clk);
    chk("reset.outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset.idle_outputs", all_outs(), 64'd0);

    // Matrix A, spike 101, with start/first-send timing and an ignored go
    load_matrix_a();
    load_spike(3'b101);
    starts0 = m_start_cnt;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("t1.busy_after_go", busy, 1);
    chk("t1.start_e0", acc.mvm_start, 0);
    @(negedge clk);
    chk("t1.start_e1", acc.mvm_start, 1);
    @(negedge clk);
    chk("t1.start_e2", {acc.mvm_start, acc.mvm_sending_cpu}, 2'b00);
    @(negedge clk);
    chk("t1.first_send", {acc.mvm_sending_cpu, acc.mvm_row_val, acc.mvm_column_val, acc.mvm_value},
        {1'b1, 2'd0, 2'd0, 8'd3});
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_done("t1", 8'd8, 8'd0, 8'd6, 5);
    chk("t1.one_start", m_start_cnt - starts0, 1);
    repeat (3) @(negedge clk);
    chk("t1.done_held", done, 1);

    // Same matrix, new spike train, no reload
    load_spike(3'b010);
    run_go("t3", 8'd0, 8'd7, 8'd0, 5);

    // Matrix B with 8-bit wrap
    clear_buf();
    wr_entry(2'd0, 2'd0, 8'd200);
    wr_entry(2'd0, 2'd1, 8'd100);
    wr_entry(2'd2, 2'd2, 8'd1);
    load_spike(3'b111);
    run_go("t2", 8'd44, 8'd0, 8'd1, 3);

    // Fill to capacity; the tenth write must be dropped
    clear_buf();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) wr_entry(2'(i / 3), 2'(i % 3), 8'(i + 1));
      else       wr_entry(2'd2, 2'd2, 8'd100);
      if (i == 7) chk("full.after8", cfg_full, 0);
      if (i == 8) chk("full.after9", cfg_full, 1);
    end
    chk("full.after10", cfg_full, 1);
    run_go("full", 8'd6, 8'd15, 8'd24, 9);

    // Reset in the middle of streaming
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (!acc.mvm_sending_cpu && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rst.reached_send", acc.mvm_sending_cpu, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst.outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clear and write in the same cycle: clear wins
    wr_entry(2'd0, 2'd0, 8'd9);
    wr_entry(2'd1, 2'd1, 8'd9);
    cfg_row = 2'd2; cfg_col = 2'd2; cfg_val = 8'd9;
    cfg_wr = 1'b1; cfg_clr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0; cfg_clr = 1'b0;
    chk("clrwr.full", cfg_full, 0);
    load_spike(3'b111);
    run_go("clrwr", 8'd0, 8'd0, 8'd0, 0);

    // Fresh run after reset
    clear_buf();
    load_matrix_a();
    load_spike(3'b101);
    run_go("post_rst", 8'd8, 8'd0, 8'd6, 5);

`ifdef MVM_SEQ_WATCHDOG_EN
    m_stall = 1'b1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    while (!acc.mvm_sending_cpu && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wd.reached_send", acc.mvm_sending_cpu, 1);
    n = 0;
    while (!error && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("wd.error", error, 1);
    chk("wd.latency_ok", (n >= 18) && (n <= 24), 1);
    chk("wd.busy_done", {busy, done}, 2'b00);
    strobes0 = m_strobe_cnt;
    repeat (10) @(negedge clk);
    chk("wd.quiet", m_strobe_cnt - strobes0, 0);
    m_stall = 1'b0;
    @(negedge clk);
    run_go("wd_recover", 8'd8, 8'd0, 8'd6, 5);
    chk("wd_recover.error", error, 0);
`else
    strobes0 = m_strobe_cnt;
    repeat (5) @(negedge clk);
    chk("idle.quiet", m_strobe_cnt - strobes0, 0);
    chk("nowd.error", error, 0);
`endif

    chk("strobe_width", m_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mvm_sequencer.md
# mvm_sequencer

Host-side controller for the sparse MVM accelerator.
- Stores one CSR-encoded 3x3 matrix (up to MAX_NNZ entries) and a 3-bit spike train written by the host.
- On `go`, drives the accelerator's start / fetch / done-list handshake entry by entry, then sends the spike train.
- Captures the three result bytes from the accelerator's toggle-signalled output stream and presents them to the host with a done flag.
- The matrix is retained across runs, so new spike trains can be applied without reloading.

## Interface
Parameters:
- MAX_NNZ, 9: depth of CSR entry buffer (matches accelerator storage)
- TIMEOUT, 255: watchdog limit in cycles (only used with MVM_SEQ_WATCHDOG_EN)

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_wr  in  1  write one CSR entry (ignored when busy or full)
- cfg_row  in  2  entry row index
- cfg_col  in  2  entry column index
- cfg_val  in  8  entry value
- cfg_clr  in  1  clear entry buffer (ignored when busy)
- cfg_full  out  1  buffer holds MAX_NNZ entries
- spike_wr  in  1  load spike register (ignored when busy)
- spike_in  in  3  spike train
- go  in  1  start run (ignored when busy)
- busy  out  1  run in progress
- done  out  1  results valid; held until next accepted go
- error  out  1  watchdog abort; held until next accepted go or cfg_clr
- res0, res1, res2  out  8 each  row results
- mvm_start  out  1  accelerator start
- mvm_row_val  out  2  row index to accelerator
- mvm_column_val  out  2  column index to accelerator
- mvm_value  out  8  value / spike byte to accelerator
- mvm_sending_cpu  out  1  data strobe to accelerator
- mvm_done_list  out  1  end-of-list strobe to accelerator
- mvm_fetch_ready  in  1  accelerator ready flag
- mvm_output_val  in  8  accelerator result byte
- mvm_sending_out  in  1  accelerator output toggle

## Operation
- Reset: state IDLE, nnz count 0, spike 0. Every output is 0: busy, done, error, cfg_full, res0-2, mvm_start, mvm_sending_cpu, mvm_done_list, mvm_row_val, mvm_column_val, mvm_value.
- Buffer writes (IDLE only):
  - `cfg_wr` stores {row,col,val} at index nnz and increments nnz; `cfg_full` = (nnz == MAX_NNZ).
  - Write when full is dropped.
  - `cfg_clr` with `cfg_wr` in the same cycle: clear wins.
  - Host supplies entries in non-decreasing row order; the sequencer does not reorder them.
- FSM states:
  - IDLE: accepted `go` sets busy, clears done and error, then goes to START.
  - START: mvm_start=1 for one cycle, then SETTLE.
  - SETTLE: one idle cycle. If idx<nnz go to SEND, else go to LIST_DONE.
  - SEND: mvm_sending_cpu=1 for one cycle with entry[idx] on row/col/value; idx++; then GAP.
  - GAP: strobes low, wait for mvm_fetch_ready=1. If idx<nnz go to SEND, else go to LIST_DONE.
  - LIST_DONE: mvm_done_list=1 for one cycle, then TRAIN_WAIT.
  - TRAIN_WAIT: skip one cycle, then wait for mvm_fetch_ready=1, then TRAIN.
  - TRAIN: mvm_sending_cpu=1, mvm_value={5'b0,spike}, one cycle, then COLLECT.
  - COLLECT: count toggles of mvm_sending_out against a registered copy (copy re-sampled in TRAIN).
    - Toggle 0 (entry into transmit, stale data) is discarded.
    - Toggles 1, 2, 3 capture mvm_output_val into res0, res1, res2.
    - After toggle 3, go to IDLE with done=1 and busy=0.
- Toggles seen outside COLLECT are ignored, including the accelerator's trailing toggle and its forced-high return.
- nnz=0: go leads to START, SETTLE, LIST_DONE directly.
- The sequencer does no arithmetic. Results are the accelerator's 8-bit sums, which wrap modulo 256.
- mvm_row_val, mvm_column_val and mvm_value hold their last driven value when strobes are low.

## Timing
- go sampled at edge E: busy=1 after E. mvm_start is high during cycle E+1 to E+2.
- First mvm_sending_cpu pulse occurs at cycle E+3.
- Entries go out no faster than one per 2 cycles.
- Spike byte strobe follows done_list by at least 2 cycles.
- Results and done update on the same edge as the toggle-3 capture, plus one register stage.
- No strobe is ever asserted for more than one consecutive cycle.
- go while busy: ignored. Reset mid-run: immediate return to reset values; the accelerator is reset by the same rst_n.

## Configuration
- MVM_SEQ_WATCHDOG_EN defined: an 8-bit-or-wider counter runs in GAP, TRAIN_WAIT and COLLECT, and restarts on every state change or captured toggle.
  - On reaching TIMEOUT: all strobes low, go to IDLE, error=1, done=0, busy=0.
- Not defined: no counter; waits are unbounded, and error is tied to 0.

## Test plan
- Load (0,0,3),(0,2,5),(1,1,7),(2,0,2),(2,2,4); spike 3'b101; go -> res0=8, res1=0, res2=6; done=1, busy=0; exactly 5 sending_cpu pulses before done_list.
- Load (0,0,200),(0,1,100),(2,2,1); spike 3'b111; go -> res0=44 (300 mod 256), res1=0, res2=1.
- Keep the first matrix, load spike 3'b010, go again -> res0=0, res1=7, res2=0 without reloading.
- Write 10 entries -> cfg_full=1 after the 9th; 10th dropped, nnz stays 9. Then cfg_clr and cfg_wr together -> nnz=0.
- Assert rst_n low during SEND -> all outputs 0 on the next cycle. A fresh go completes normally.
- With MVM_SEQ_WATCHDOG_EN and TIMEOUT=20, hold mvm_fetch_ready=0 after the first send -> error=1 about 20 cycles later, busy=0, no further strobes.
